// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared sizing and requester index constants for the CDB arbiter
package cdb_pkg;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int PTR_W   = 2;

  localparam int REQ_INT0 = 0;
  localparam int REQ_INT1 = 1;
  localparam int REQ_MULT = 2;
  localparam int REQ_LS   = 3;

  typedef logic [PTR_W-1:0] ptr_t;

  // The pointer is exactly PTR_W bits wide, so the wrap to 0 is the natural overflow.
  function automatic ptr_t ptr_after(input ptr_t k);
    return k + ptr_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin grant with flush mask
module rr_arbiter4
  import cdb_pkg::*;
(
  input  logic [3:0] req,
  input  ptr_t       ptr,
  input  logic       flush,
  output logic [3:0] gnt,
  output ptr_t       idx,
  output logic       valid
);

  logic [3:0] req_m;
  ptr_t       cand;

  // Search starts at ptr and walks upward modulo 4; the first live request wins.
  always_comb begin
    req_m = flush ? 4'b0000 : req;
    valid = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + ptr_t'(k);
      if (!valid && req_m[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    gnt = valid ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Common Data Bus arbiter with registered broadcast
// Optional CDB_MULT_PRIORITY_EN: the multiplier always wins and does not move the pointer.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = cdb_pkg::NUM_REQ,
  parameter int TAG_W   = cdb_pkg::TAG_W,
  parameter int DATA_W  = cdb_pkg::DATA_W
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*TAG_W-1:0]  Req_Tag,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  input  logic [NUM_REQ-1:0]        Req_Branch,
  input  logic [NUM_REQ-1:0]        Req_Branch_Taken,
  output logic [NUM_REQ-1:0]        Gnt,
  input  logic                      RB_Flush_Valid,
  output logic [TAG_W-1:0]          CDB_Tag_Out,
  output logic [DATA_W-1:0]         CDB_Data_Out,
  output logic                      CDB_Valid_Out,
  output logic                      CDB_Branch_Out,
  output logic                      CDB_Branch_Taken_Out
);

  ptr_t        ptr;
  logic [3:0]  rr_req;
  logic [3:0]  rr_gnt;
  ptr_t        rr_idx;
  logic        rr_valid;

  logic [3:0]  gnt_c;
  ptr_t        sel;
  logic        any_gnt;
  logic        ptr_adv;

  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;
  logic              sel_branch;
  logic              sel_taken;

  rr_arbiter4 u_rr (
    .req   (rr_req),
    .ptr   (ptr),
    .flush (RB_Flush_Valid),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

`ifdef CDB_MULT_PRIORITY_EN
  logic mult_win;

  // Mult is removed from the rotation; it pre-empts everyone but never consumes a turn.
  always_comb begin
    mult_win = Req[REQ_MULT] & ~RB_Flush_Valid;
    rr_req   = Req[3:0] & ~(4'b0001 << REQ_MULT);
    gnt_c    = mult_win ? (4'b0001 << REQ_MULT) : rr_gnt;
    sel      = mult_win ? ptr_t'(REQ_MULT) : rr_idx;
    any_gnt  = mult_win | rr_valid;
    ptr_adv  = ~mult_win & rr_valid;
  end
`else
  always_comb begin
    rr_req  = Req[3:0];
    gnt_c   = rr_gnt;
    sel     = rr_idx;
    any_gnt = rr_valid;
    ptr_adv = rr_valid;
  end
`endif

  assign Gnt = Rst ? gnt_c : '0;

  always_comb begin
    sel_tag    = Req_Tag[sel*TAG_W +: TAG_W];
    sel_data   = Req_Data[sel*DATA_W +: DATA_W];
    sel_branch = Req_Branch[sel];
    sel_taken  = Req_Branch_Taken[sel];
  end

  // Tag and data hold across idle cycles; the branch flags are only meaningful with valid.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr                  <= '0;
      CDB_Tag_Out          <= '0;
      CDB_Data_Out         <= '0;
      CDB_Valid_Out        <= 1'b0;
      CDB_Branch_Out       <= 1'b0;
      CDB_Branch_Taken_Out <= 1'b0;
    end else begin
      if (ptr_adv) begin
        ptr <= ptr_after(sel);
      end
      if (any_gnt) begin
        CDB_Tag_Out          <= sel_tag;
        CDB_Data_Out         <= sel_data;
        CDB_Valid_Out        <= 1'b1;
        CDB_Branch_Out       <= sel_branch;
        CDB_Branch_Taken_Out <= sel_taken;
      end else begin
        CDB_Valid_Out        <= 1'b0;
        CDB_Branch_Out       <= 1'b0;
        CDB_Branch_Taken_Out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [3:0]   Req;
  logic [19:0]  Req_Tag;
  logic [127:0] Req_Data;
  logic [3:0]   Req_Branch;
  logic [3:0]   Req_Branch_Taken;
  logic [3:0]   Gnt;
  logic         RB_Flush_Valid;
  logic [4:0]   CDB_Tag_Out;
  logic [31:0]  CDB_Data_Out;
  logic         CDB_Valid_Out;
  logic         CDB_Branch_Out;
  logic         CDB_Branch_Taken_Out;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter dut (
    .Clk                  (Clk),
    .Rst                  (Rst),
    .Req                  (Req),
    .Req_Tag              (Req_Tag),
    .Req_Data             (Req_Data),
    .Req_Branch           (Req_Branch),
    .Req_Branch_Taken     (Req_Branch_Taken),
    .Gnt                  (Gnt),
    .RB_Flush_Valid       (RB_Flush_Valid),
    .CDB_Tag_Out          (CDB_Tag_Out),
    .CDB_Data_Out         (CDB_Data_Out),
    .CDB_Valid_Out        (CDB_Valid_Out),
    .CDB_Branch_Out       (CDB_Branch_Out),
    .CDB_Branch_Taken_Out (CDB_Branch_Taken_Out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [4:0] tag, input logic [31:0] data);
    Req_Tag[i*5 +: 5]   = tag;
    Req_Data[i*32 +: 32] = data;
  endtask

  initial begin
    Rst = 1'b0;
    Req = 4'b1111;
    Req_Tag = '0;
    Req_Data = '0;
    Req_Branch = '0;
    Req_Branch_Taken = '0;
    RB_Flush_Valid = 1'b0;

    #2;
    chk("rst_gnt", 64'(Gnt), 64'h0);
    chk("rst_valid", 64'(CDB_Valid_Out), 64'h0);
    chk("rst_tag", 64'(CDB_Tag_Out), 64'h0);
    chk("rst_data", 64'(CDB_Data_Out), 64'h0);
    chk("rst_branch", 64'({CDB_Branch_Out, CDB_Branch_Taken_Out}), 64'h0);
    Req = 4'b0000;
    @(posedge Clk);
    #2 Rst = 1'b1;

    // single request, latency and drop back to idle
    set_slot(0, 5'd7, 32'hDEADBEEF);
    Req = 4'b0001;
    #1 chk("t1_gnt", 64'(Gnt), 64'h1);
    tick();
    chk("t1_valid", 64'(CDB_Valid_Out), 64'h1);
    chk("t1_tag", 64'(CDB_Tag_Out), 64'h7);
    chk("t1_data", 64'(CDB_Data_Out), 64'hDEADBEEF);
    Req = 4'b0000;
    #1 chk("t1_gnt_drop", 64'(Gnt), 64'h0);
    tick();
    chk("t1_valid_low", 64'(CDB_Valid_Out), 64'h0);
    chk("t1_tag_hold", 64'(CDB_Tag_Out), 64'h7);

    // ptr is 1; a grant to LS wraps it back to 0
    Req = 4'b1000;
    #1 chk("wrap_gnt", 64'(Gnt), 64'h8);
    tick();
    Req = 4'b0000;

    for (int i = 0; i < 4; i++) set_slot(i, 5'(10 + i), 32'hA0 + 32'(i));

`ifndef CDB_MULT_PRIORITY_EN
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_gnt", 64'(Gnt), 64'(4'b0001 << (k % 4)));
      tick();
      chk("rr_valid", 64'(CDB_Valid_Out), 64'h1);
      chk("rr_tag", 64'(CDB_Tag_Out), 64'(10 + (k % 4)));
    end
    Req = 4'b0000;
    tick();
    chk("rr_idle", 64'(CDB_Valid_Out), 64'h0);
`else
    Req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("mp_gnt", 64'(Gnt), 64'h4);
      tick();
      chk("mp_tag", 64'(CDB_Tag_Out), 64'd12);
    end
    Req = 4'b1011;
    #1 chk("mp_ptr_kept", 64'(Gnt), 64'h1);
    tick();
    chk("mp_tag0", 64'(CDB_Tag_Out), 64'd10);
    Req = 4'b0000;
    tick();
`endif

    // branch result broadcast for exactly one cycle (ptr=1)
    Req_Branch = 4'b0010;
    Req_Branch_Taken = 4'b0010;
    Req = 4'b0010;
    #1 chk("br_gnt", 64'(Gnt), 64'h2);
    tick();
    chk("br_flags", 64'({CDB_Valid_Out, CDB_Branch_Out, CDB_Branch_Taken_Out}), 64'h7);
    Req = 4'b0000;
    Req_Branch = '0;
    Req_Branch_Taken = '0;
    tick();
    chk("br_clear", 64'({CDB_Valid_Out, CDB_Branch_Out, CDB_Branch_Taken_Out}), 64'h0);

    // flush: previous broadcast is kept, grants blocked for two cycles (ptr=2)
    Req = 4'b1000;
    #1 chk("fl_pre_gnt", 64'(Gnt), 64'h8);
    tick();
    chk("fl_pre_valid", 64'(CDB_Valid_Out), 64'h1);
    RB_Flush_Valid = 1'b1;
    #1 chk("fl_gnt0", 64'(Gnt), 64'h0);
    chk("fl_not_retracted", 64'(CDB_Valid_Out), 64'h1);
    tick();
    chk("fl_valid0", 64'(CDB_Valid_Out), 64'h0);
    chk("fl_gnt1", 64'(Gnt), 64'h0);
    tick();
    chk("fl_valid1", 64'(CDB_Valid_Out), 64'h0);
    RB_Flush_Valid = 1'b0;
    #1 chk("fl_after_gnt", 64'(Gnt), 64'h8);
    tick();
    chk("fl_after_valid", 64'(CDB_Valid_Out), 64'h1);
    chk("fl_after_tag", 64'(CDB_Tag_Out), 64'd13);
    Req = 4'b0000;

    // asynchronous reset mid-cycle with ptr=2 and a live broadcast
    Req = 4'b0010;
    #1 chk("ar_gnt", 64'(Gnt), 64'h2);
    tick();
    Req = 4'b0000;
    chk("ar_valid_pre", 64'(CDB_Valid_Out), 64'h1);
    #2 Rst = 1'b0;
    #1;
    chk("ar_valid", 64'(CDB_Valid_Out), 64'h0);
    chk("ar_tag", 64'(CDB_Tag_Out), 64'h0);
    chk("ar_data", 64'(CDB_Data_Out), 64'h0);
    Req = 4'b1111;
    #1 chk("ar_gnt_in_rst", 64'(Gnt), 64'h0);
    #2 Rst = 1'b1;
`ifndef CDB_MULT_PRIORITY_EN
    #1 chk("ar_first_gnt", 64'(Gnt), 64'h1);
    tick();
    chk("ar_first_tag", 64'(CDB_Tag_Out), 64'd10);
`else
    #1 chk("ar_first_gnt", 64'(Gnt), 64'h4);
    tick();
    chk("ar_first_tag", 64'(CDB_Tag_Out), 64'd12);
`endif
    chk("ar_first_valid", 64'(CDB_Valid_Out), 64'h1);
    Req = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
